// File: rtl/adxl345_pkg.sv
// ADXL345 register map, SPI command encoding and scheduler state type.
// Shared by the sample scheduler and the configuration sequencer.
package adxl345_pkg;

  localparam logic [5:0] DEVID       = 6'h00;
  localparam logic [5:0] POWER_CTL   = 6'h2D;
  localparam logic [5:0] INT_ENABLE  = 6'h2E;
  localparam logic [5:0] DATA_FORMAT = 6'h31;
  localparam logic [5:0] DATAX0      = 6'h32;
  localparam logic [5:0] DATAX1      = 6'h33;
  localparam logic [5:0] DATAY0      = 6'h34;
  localparam logic [5:0] DATAY1      = 6'h35;
  localparam logic [5:0] DATAZ0      = 6'h36;
  localparam logic [5:0] DATAZ1      = 6'h37;
  localparam logic [5:0] FIFO_CTL    = 6'h38;

  localparam logic REG_READ  = 1'b1;
  localparam logic REG_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_RSP,
    EMIT
  } sched_state_t;

  // {R/W, multi-byte, address, don't-care data byte}
  function automatic logic [15:0] adxl345_read_cmd(input logic [5:0] addr);
    return {REG_READ, 1'b0, addr, 8'h00};
  endfunction

endpackage

// File: rtl/periodic_tick.sv
// Free-running period counter that emits a one-cycle tick on each wrap.
// Held at zero while disabled, so the first tick lands PERIOD cycles after enable.
module periodic_tick #(
  parameter int PERIOD = 100000
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = (PERIOD > 2) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge sys_clk) begin
    if (reset || !enable) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (count == CW'(PERIOD - 1)) begin
      count <= '0;
      tick  <= 1'b1;
    end else begin
      count <= count + CW'(1);
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/adxl345_sample_scheduler.sv
// Periodically reads DATAX0..DATAZ1 over the shared SPI command/response
// streams and emits one 48-bit {Z,Y,X} sample per acquisition.
module adxl345_sample_scheduler
  import adxl345_pkg::*;
#(
  parameter int SAMPLE_PERIOD  = 100000,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TRANSFER_WIDTH = 16
) (
  input  logic                      sys_clk,
  input  logic                      reset,
  input  logic                      enable,
  output logic                      command_tvalid,
  input  logic                      command_tready,
  output logic [TRANSFER_WIDTH-1:0] command_tdata,
  input  logic                      response_tvalid,
  output logic                      response_tready,
  input  logic [TRANSFER_WIDTH-1:0] response_tdata,
  output logic                      sample_tvalid,
  input  logic                      sample_tready,
  output logic [47:0]               sample_tdata,
  output logic                      sample_tlast,
  output logic [5:0]                sample_tkeep,
  output logic                      busy,
  output logic                      timeout_error,
  output logic [7:0]                overrun_count
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  generate
    if (TRANSFER_WIDTH != 16) begin : g_width_check
      $error("adxl345_sample_scheduler: TRANSFER_WIDTH must be 16");
    end
    if (SAMPLE_PERIOD < 2) begin : g_period_check
      $error("adxl345_sample_scheduler: SAMPLE_PERIOD must be >= 2");
    end
  endgenerate

  sched_state_t  state;
  logic [2:0]    idx;
  logic [TW-1:0] tcnt;
  logic [7:0]    bytes [5];
  logic          tick;
  logic          unused_rsp_bits;

  assign unused_rsp_bits = &{1'b0, response_tdata[TRANSFER_WIDTH-1:8]};

  // Stray or late responses are always drained so the SPI master never stalls.
  assign response_tready = 1'b1;
  assign sample_tlast    = 1'b1;
  assign sample_tkeep    = 6'h3F;

  periodic_tick #(
    .PERIOD (SAMPLE_PERIOD)
  ) u_tick (
    .sys_clk (sys_clk),
    .reset   (reset),
    .enable  (enable),
    .tick    (tick)
  );

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state          <= IDLE;
      idx            <= '0;
      tcnt           <= '0;
      command_tvalid <= 1'b0;
      command_tdata  <= '0;
      sample_tvalid  <= 1'b0;
      sample_tdata   <= '0;
      busy           <= 1'b0;
      timeout_error  <= 1'b0;
      overrun_count  <= '0;
    end else begin
      // Any tick outside IDLE is a dropped sample, including the EMIT-exit cycle.
      if (tick && state != IDLE && overrun_count != 8'hFF) begin
        overrun_count <= overrun_count + 8'd1;
      end
      case (state)
        IDLE: begin
          if (tick && enable) begin
            state          <= SEND;
            idx            <= '0;
            busy           <= 1'b1;
            command_tvalid <= 1'b1;
            command_tdata  <= adxl345_read_cmd(DATAX0);
          end
        end
        SEND: begin
          if (command_tready) begin
            command_tvalid <= 1'b0;
            tcnt           <= '0;
            state          <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (response_tvalid) begin
            if (idx == 3'd5) begin
              state         <= EMIT;
              sample_tvalid <= 1'b1;
              sample_tdata  <= {response_tdata[7:0], bytes[4], bytes[3],
                                bytes[2], bytes[1], bytes[0]};
            end else begin
              idx            <= idx + 3'd1;
              state          <= SEND;
              command_tvalid <= 1'b1;
              command_tdata  <= adxl345_read_cmd(DATAX0 + {3'b000, idx + 3'd1});
            end
          end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            timeout_error <= 1'b1;
            busy          <= 1'b0;
            state         <= IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        EMIT: begin
          if (sample_tready) begin
            sample_tvalid <= 1'b0;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Byte capture carries no reset; a timed-out acquisition is simply overwritten.
  always_ff @(posedge sys_clk) begin
    if (state == WAIT_RSP && response_tvalid && idx != 3'd5) begin
      bytes[idx] <= response_tdata[7:0];
    end
  end

endmodule

// File: tb/tb_adxl345_sample_scheduler.sv
// Scoreboard bench for adxl345_sample_scheduler: an SPI responder model feeds
// bytes, expected samples are queued as responses are driven and popped on emit.
module tb_adxl345_sample_scheduler;

  localparam int P  = 50;
  localparam int TO = 16;

  logic        sys_clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        command_tvalid;
  logic        command_tready = 1'b1;
  logic [15:0] command_tdata;
  logic        response_tvalid = 1'b0;
  logic        response_tready;
  logic [15:0] response_tdata = 16'h0000;
  logic        sample_tvalid;
  logic        sample_tready = 1'b1;
  logic [47:0] sample_tdata;
  logic        sample_tlast;
  logic [5:0]  sample_tkeep;
  logic        busy;
  logic        timeout_error;
  logic [7:0]  overrun_count;

  adxl345_sample_scheduler #(
    .SAMPLE_PERIOD  (P),
    .TIMEOUT_CYCLES (TO),
    .TRANSFER_WIDTH (16)
  ) dut (
    .sys_clk         (sys_clk),
    .reset           (reset),
    .enable          (enable),
    .command_tvalid  (command_tvalid),
    .command_tready  (command_tready),
    .command_tdata   (command_tdata),
    .response_tvalid (response_tvalid),
    .response_tready (response_tready),
    .response_tdata  (response_tdata),
    .sample_tvalid   (sample_tvalid),
    .sample_tready   (sample_tready),
    .sample_tdata    (sample_tdata),
    .sample_tlast    (sample_tlast),
    .sample_tkeep    (sample_tkeep),
    .busy            (busy),
    .timeout_error   (timeout_error),
    .overrun_count   (overrun_count)
  );

  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Responder / monitor state
  bit          rand_cready = 1'b0;
  int          rsp_lat = 1;
  bit          withhold_en = 1'b0;
  int          withhold_idx = 2;
  int          exp_idx = 0;
  logic [7:0]  seed = 8'h00;
  logic [47:0] partial = '0;
  logic [47:0] exp_q [$];
  int          outstanding = 0;
  int          cmd_count = 0;
  int          sample_count = 0;
  int          stab_err_cmd = 0;
  int          stab_err_smp = 0;
  int          timeouts_seen = 0;
  bit          prev_cmd_stall = 1'b0;
  logic [15:0] prev_cd = '0;
  bit          prev_smp_stall = 1'b0;
  logic [47:0] prev_sd = '0;
  bit          rsp_pend = 1'b0;
  int          rsp_wait = 0;
  logic [7:0]  rsp_byte = '0;
  int          to_k = -1;
  bit          late_rsp = 1'b0;
  logic        nx_rv = 1'b0;
  logic [15:0] nx_rd = '0;
  logic        nx_cr = 1'b1;

  always begin
    @(negedge sys_clk);
    if (reset) begin
      exp_q.delete();
      exp_idx        = 0;
      partial        = '0;
      outstanding    = 0;
      rsp_pend       = 1'b0;
      to_k           = -1;
      late_rsp       = 1'b0;
      prev_cmd_stall = 1'b0;
      prev_smp_stall = 1'b0;
      nx_rv          = 1'b0;
      nx_cr          = 1'b1;
    end else begin
      if (to_k >= 0) begin
        to_k++;
        if (to_k == TO) begin
          check_value("timeout_not_early", timeout_error, 1'b0);
        end else if (to_k == TO + 1) begin
          check_value("timeout_flag", timeout_error, 1'b1);
          check_value("timeout_busy_low", busy, 1'b0);
          timeouts_seen++;
          outstanding--;
          to_k     = -1;
          nx_rv    = 1'b1;
          nx_rd    = 16'hA5EE;
          late_rsp = 1'b1;
        end
      end

      if (command_tvalid && prev_cmd_stall && command_tdata !== prev_cd) stab_err_cmd++;
      if (command_tvalid && command_tready) begin
        cmd_count++;
        check_value("cmd_data", command_tdata, {1'b1, 1'b0, 6'(6'h32 + exp_idx), 8'h00});
        check_value("one_outstanding", outstanding, 0);
        outstanding++;
        if (withhold_en && exp_idx == withhold_idx) begin
          withhold_en = 1'b0;
          to_k        = 0;
          exp_idx     = 0;
          partial     = '0;
          seed        = seed + 8'h5B;
        end else begin
          rsp_byte = 8'((exp_idx + 1) * 17) ^ seed;
          partial[exp_idx*8 +: 8] = rsp_byte;
          rsp_pend = 1'b1;
          rsp_wait = rsp_lat;
          exp_idx++;
          if (exp_idx == 6) begin
            exp_q.push_back(partial);
            exp_idx = 0;
            seed    = seed + 8'h5B;
          end
        end
      end
      prev_cmd_stall = command_tvalid && !command_tready;
      prev_cd        = command_tdata;

      if (response_tvalid && response_tready) begin
        nx_rv = 1'b0;
        if (late_rsp) late_rsp = 1'b0;
        else outstanding--;
      end else if (!response_tvalid && rsp_pend) begin
        if (rsp_wait == 0) begin
          nx_rv    = 1'b1;
          nx_rd    = {8'hC3, rsp_byte};
          rsp_pend = 1'b0;
        end else begin
          rsp_wait--;
        end
      end

      if (sample_tvalid && prev_smp_stall && sample_tdata !== prev_sd) stab_err_smp++;
      if (sample_tvalid && sample_tready) begin
        sample_count++;
        if (exp_q.size() == 0) begin
          check_value("sample_unexpected", 1, 0);
        end else begin
          check_value("sample_data", sample_tdata, exp_q.pop_front());
          check_value("sample_tlast", sample_tlast, 1'b1);
          check_value("sample_tkeep", sample_tkeep, 6'h3F);
        end
      end
      prev_smp_stall = sample_tvalid && !sample_tready;
      prev_sd        = sample_tdata;

      nx_cr = rand_cready ? 1'($urandom_range(1, 0)) : 1'b1;
    end
    @(posedge sys_clk);
    #1;
    response_tvalid = nx_rv;
    response_tdata  = nx_rd;
    command_tready  = nx_cr;
  end

  task automatic tick_cycle();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_samples(input string tag, input int n, input int budget);
    int s0 = sample_count;
    int k = 0;
    while (sample_count < s0 + n && k < budget) begin
      tick_cycle();
      k++;
    end
    check_value(tag, sample_count - s0, n);
  endtask

  task automatic wait_sample_valid(input string tag);
    int k = 0;
    while (!sample_tvalid && k < 300) begin
      tick_cycle();
      k++;
    end
    check_value(tag, sample_tvalid, 1'b1);
  endtask

  task automatic check_reset(input string tag);
    check_value({tag, ".cmd_tvalid"}, command_tvalid, 1'b0);
    check_value({tag, ".cmd_tdata"}, command_tdata, 16'h0000);
    check_value({tag, ".rsp_tready"}, response_tready, 1'b1);
    check_value({tag, ".smp_tvalid"}, sample_tvalid, 1'b0);
    check_value({tag, ".smp_tdata"}, sample_tdata, 48'h0);
    check_value({tag, ".busy"}, busy, 1'b0);
    check_value({tag, ".timeout"}, timeout_error, 1'b0);
    check_value({tag, ".overrun"}, overrun_count, 8'd0);
  endtask

  initial begin
    int n;
    int c0;
    int s0;

    repeat (3) tick_cycle();
    @(negedge sys_clk);
    check_reset("rst_init");
    tick_cycle();
    reset = 1'b0;

    // Disabled: no commands at all
    c0 = cmd_count;
    repeat (150) tick_cycle();
    check_value("disabled_no_cmd", cmd_count - c0, 0);
    check_value("disabled_busy", busy, 1'b0);

    // First tick lands P cycles after enable, command one cycle later
    enable = 1'b1;
    n = 0;
    while (n < 200) begin
      @(negedge sys_clk);
      n++;
      if (command_tvalid) break;
    end
    check_value("first_cmd_latency", n, P + 2);
    wait_samples("basic_sample", 1, 400);
    check_value("basic_overrun", overrun_count, 8'd0);
    check_value("basic_timeout", timeout_error, 1'b0);

    // Sink stall: four ticks fall inside the stalled acquisition
    tick_cycle();
    sample_tready = 1'b0;
    wait_sample_valid("stall_valid");
    repeat (200) tick_cycle();
    check_value("stall_overrun", overrun_count, 8'd4);
    check_value("stall_stable", stab_err_smp, 0);
    check_value("stall_busy", busy, 1'b1);
    sample_tready = 1'b1;
    wait_samples("stall_release", 1, 20);
    wait_samples("stall_resume", 1, 300);

    // Withheld third response -> timeout, late response discarded
    withhold_en = 1'b1;
    wait_samples("timeout_recover", 1, 400);
    check_value("timeout_seen", timeouts_seen, 1);
    check_value("timeout_sticky", timeout_error, 1'b1);

    // Random command backpressure
    rand_cready = 1'b1;
    wait_samples("rand_cready", 2, 800);
    rand_cready = 1'b0;
    check_value("cmd_stable", stab_err_cmd, 0);

    // Enable dropped during read 3: sample completes, then silence
    n = 0;
    while (exp_idx != 3 && n < 300) begin
      tick_cycle();
      n++;
    end
    check_value("reach_read3", exp_idx, 3);
    enable = 1'b0;
    wait_samples("enable_drop_done", 1, 200);
    c0 = cmd_count;
    s0 = sample_count;
    repeat (200) tick_cycle();
    check_value("enable_drop_no_cmd", cmd_count - c0, 0);
    check_value("enable_drop_no_smp", sample_count - s0, 0);
    check_value("enable_drop_busy", busy, 1'b0);

    // Reset while waiting for a response
    rsp_lat = 6;
    enable  = 1'b1;
    n = 0;
    while (outstanding != 1 && n < 300) begin
      tick_cycle();
      n++;
    end
    check_value("reach_wait_rsp", outstanding, 1);
    reset = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    check_reset("rst_wait");
    tick_cycle();
    reset   = 1'b0;
    rsp_lat = 1;
    wait_samples("after_rst_wait", 1, 300);

    // Reset while a sample is being emitted
    sample_tready = 1'b0;
    wait_sample_valid("emit_valid");
    reset = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    check_reset("rst_emit");
    tick_cycle();
    reset         = 1'b0;
    sample_tready = 1'b1;
    wait_samples("after_rst_emit", 1, 300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
